pingpong_buf_ctrl: RTL

Ping-pong controller that sequences two `buffer` instances (bank 0/1) between a streaming tile loader and the sparse tensor core operand consumer. It fills one bank while the other drains, so loading tile k+1 overlaps consumption of tile k. It drives the write/read enables and addresses of both buffers and muxes the read data. A start pulse launches a job; a done pulse ends it.

---
 rtl/pingpong_pkg.sv | 15 +
 rtl/pingpong_buf_ctrl_if.sv | 33 +++
 rtl/tile_ptr.sv | 40 ++++
 rtl/pingpong_buf_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// Shared definitions for the ping-pong buffer controller: FSM encoding and
// the configuration legality rule applied when a job is launched.
package pingpong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic cfg_legal(input int len, input int tiles, input int depth);
    return (len >= 1) && (len <= depth) && (tiles >= 1);
  endfunction

endpackage

// File: rtl/pingpong_buf_ctrl_if.sv
// Loader stream, consumer stream and the two-bank buffer bus of the
// ping-pong controller. master = controller side, slave = surroundings.
interface pingpong_buf_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic [1:0]            buf_wr_en;
  logic [ADDR_WIDTH-1:0] buf_wr_addr;
  logic [DATA_WIDTH-1:0] buf_wr_data;
  logic [1:0]            buf_rd_en;
  logic [ADDR_WIDTH-1:0] buf_rd_addr;
  logic [DATA_WIDTH-1:0] buf_rd_data0;
  logic [DATA_WIDTH-1:0] buf_rd_data1;

  modport master (
    input  in_valid, in_data, out_ready, buf_rd_data0, buf_rd_data1,
    output in_ready, out_valid, out_data, out_last,
           buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_en, buf_rd_addr
  );

  modport slave (
    output in_valid, in_data, out_ready, buf_rd_data0, buf_rd_data1,
    input  in_ready, out_valid, out_data, out_last,
           buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_en, buf_rd_addr
  );
endinterface

// File: rtl/tile_ptr.sv
// Beat pointer for one side of the ping-pong: beat counter wrapping at len-1,
// bank select that toggles on each wrap, and a count of completed tiles.
module tile_ptr import pingpong_pkg::*; #(
  parameter int ADDR_WIDTH = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic                  wrap,
  output logic                  bank,
  output logic [CNT_WIDTH-1:0]  tiles
);

  assign wrap = ({1'b0, cnt} == (len - (ADDR_WIDTH+1)'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      bank  <= 1'b0;
      tiles <= '0;
    end else if (clr) begin
      cnt   <= '0;
      bank  <= 1'b0;
      tiles <= '0;
    end else if (inc) begin
      if (wrap) begin
        cnt   <= '0;
        bank  <= ~bank;
        tiles <= tiles + CNT_WIDTH'(1);
      end else begin
        cnt   <= cnt + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong controller: fills one buffer bank from the loader while the other
// drains to the consumer, for cfg_tiles tiles of cfg_len beats each.
module pingpong_buf_ctrl import pingpong_pkg::*; #(
  parameter int DATA_WIDTH   = 64,
  parameter int BUFFER_DEPTH = 64,
  parameter int ADDR_WIDTH   = 6,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   cfg_len,
  input  logic [CNT_WIDTH-1:0]  cfg_tiles,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  pingpong_buf_ctrl_if.master   bus
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   len_q;
  logic [CNT_WIDTH-1:0]  tiles_q;
  logic [1:0]            full;
  logic                  legal, launch, run;
  logic                  in_ready, out_valid, wr_hs, rd_hs, job_end;
  logic [ADDR_WIDTH-1:0] wr_cnt, rd_cnt;
  logic                  wr_wrap, rd_wrap, wr_bank, rd_bank;
  logic [CNT_WIDTH-1:0]  tiles_wr, tiles_rd;
  logic [DATA_WIDTH-1:0] rd_mux;

  assign legal    = cfg_legal(int'(cfg_len), int'(cfg_tiles), BUFFER_DEPTH);
  assign launch   = (state == IDLE) && start && legal;
  assign run      = (state == RUN);

  // Readiness depends on registered state only, never on in_valid.
  assign in_ready  = run && !full[wr_bank] && (tiles_wr < tiles_q);
  assign out_valid = run && full[rd_bank];
  assign wr_hs     = in_ready && bus.in_valid;
  assign rd_hs     = out_valid && bus.out_ready;
  assign job_end   = rd_hs && rd_wrap && (tiles_rd == (tiles_q - CNT_WIDTH'(1)));

  tile_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_wr_ptr (
    .clk(clk), .rst(rst), .clr(launch), .inc(wr_hs), .len(len_q),
    .cnt(wr_cnt), .wrap(wr_wrap), .bank(wr_bank), .tiles(tiles_wr)
  );

  tile_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_rd_ptr (
    .clk(clk), .rst(rst), .clr(launch), .inc(rd_hs), .len(len_q),
    .cnt(rd_cnt), .wrap(rd_wrap), .bank(rd_bank), .tiles(tiles_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= (state == IDLE) && start && !legal;
    end
  end

  // Job configuration is data: captured at launch, never reset.
  always_ff @(posedge clk) begin
    if (launch) begin
      len_q   <= cfg_len;
      tiles_q <= cfg_tiles;
    end
  end

  // Set and clear always hit opposite banks, so both may apply in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
    end else if (launch) begin
      full <= '0;
    end else begin
      if (wr_hs && wr_wrap) full[wr_bank] <= 1'b1;
      if (rd_hs && rd_wrap) full[rd_bank] <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (launch) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (job_end) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_mux          = rd_bank ? bus.buf_rd_data1 : bus.buf_rd_data0;

  assign bus.in_ready    = in_ready;
  assign bus.buf_wr_en   = wr_hs ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign bus.buf_wr_addr = wr_cnt;
  assign bus.buf_wr_data = wr_hs ? bus.in_data : '0;
  assign bus.buf_rd_en   = out_valid ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
  assign bus.buf_rd_addr = rd_cnt;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = out_valid ? rd_mux : '0;
  assign bus.out_last    = out_valid && rd_wrap;

endmodule
